// File: rtl/token_divider_pkg.sv
// Shared types and reset defaults for the multi-channel token rate divider.
// No ports. This package provides:
//   tok_mode_t - KEEP forwards every K-th token; DROP suppresses every K-th token.
//   DEF_DIV    - divisor K loaded at reset.
//   DEF_MODE   - mode loaded at reset.
// The reset defaults reproduce the original single-channel halver.
package token_divider_pkg;

  typedef enum logic {
    MODE_KEEP = 1'b0,
    MODE_DROP = 1'b1
  } tok_mode_t;

  localparam int unsigned DEF_DIV  = 2;
  localparam tok_mode_t   DEF_MODE = MODE_KEEP;

endpackage

// File: rtl/token_divider_if.sv
// Bundle of the token and configuration signals of token_divider.
// Signals:
//   a        - input tokens, one bit per lane
//   cfg_we   - load cfg_div/cfg_mode this cycle
//   cfg_div  - new divisor K (0 is taken as 1)
//   cfg_mode - 0 = KEEP, 1 = DROP
//   cnt_clr  - clear the emitted-token counter
//   b        - registered output tokens
//   tok_cnt  - saturating count of emitted tokens
// Modports:
//   master - the producer/controller side
//   slave  - the divider side
interface token_divider_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DIV_W = 4,
  parameter int unsigned CNT_W = 16
) ();

  logic [N_CH-1:0]  a;
  logic             cfg_we;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_mode;
  logic             cnt_clr;
  logic [N_CH-1:0]  b;
  logic [CNT_W-1:0] tok_cnt;

  modport master (
    output a, cfg_we, cfg_div, cfg_mode, cnt_clr,
    input  b, tok_cnt
  );

  modport slave (
    input  a, cfg_we, cfg_div, cfg_mode, cnt_clr,
    output b, tok_cnt
  );

endinterface

// File: rtl/token_divider_lane.sv
// One lane of the token divider. It owns the lane's phase counter and its
// output token flop.
// Ports:
//   clk, rst - clock; synchronous active-high reset
//   k        - current divisor (always >= 1)
//   mode     - current KEEP/DROP mode
//   cfg_we   - config load this cycle; restarts the phase
//   a        - input token
//   b_d      - next value of b, used by the top-level popcount
//   b        - registered output token
module token_divider_lane
  import token_divider_pkg::*;
#(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] k,
  input  tok_mode_t        mode,
  input  logic             cfg_we,
  input  logic             a,
  output logic             b_d,
  output logic             b
);

  logic [DIV_W-1:0] ph_q, ph_d;
  logic             b_q;
  logic             hit;

  always_comb begin
    hit  = a && (ph_q == (k - DIV_W'(1)));
    ph_d = ph_q;
    // This cycle's token is judged on the old phase, but a config load
    // discards its advance so the new K starts from phase 0.
    if (cfg_we) begin
      ph_d = '0;
    end else if (a) begin
      ph_d = hit ? '0 : ph_q + DIV_W'(1);
    end
    b_d = 1'b0;
    if (a) begin
      b_d = (mode == MODE_KEEP) ? hit : ~hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q <= '0;
      b_q  <= 1'b0;
    end else begin
      ph_q <= ph_d;
      b_q  <= b_d;
    end
  end

  assign b = b_q;

endmodule

// File: rtl/token_divider.sv
// Multi-channel serial token rate divider. Each lane forwards every K-th
// token (KEEP) or suppresses every K-th token (DROP). K and the mode are
// shared by all lanes and can be changed at run time. A saturating counter
// totals the tokens emitted on all lanes.
// Ports:
//   clk, rst - clock; synchronous active-high reset (overrides cfg_we/cnt_clr)
//   bus      - token_divider_if slave: a, cfg_we, cfg_div, cfg_mode, cnt_clr
//              in; b and tok_cnt out (both registered)
module token_divider
  import token_divider_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DIV_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  token_divider_if.slave bus
);

  localparam int unsigned SUM_W = CNT_W + $clog2(N_CH + 1);

  logic [DIV_W-1:0] k_q, k_d;
  tok_mode_t        mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  b_next;
  logic [N_CH-1:0]  b_lane;
  logic [SUM_W-1:0] pop;
  logic [SUM_W-1:0] sum;

  always_comb begin
    k_d    = k_q;
    mode_d = mode_q;
    if (bus.cfg_we) begin
      k_d    = (bus.cfg_div == '0) ? DIV_W'(1) : bus.cfg_div;
      mode_d = tok_mode_t'(bus.cfg_mode);
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      pop = pop + SUM_W'(b_next[i]);
    end
    sum = SUM_W'(cnt_q) + pop;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (sum > SUM_W'({CNT_W{1'b1}})) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q    <= DIV_W'(DEF_DIV);
      mode_q <= DEF_MODE;
      cnt_q  <= '0;
    end else begin
      k_q    <= k_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    token_divider_lane #(
      .DIV_W(DIV_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .k      (k_q),
      .mode   (mode_q),
      .cfg_we (bus.cfg_we),
      .a      (bus.a[i]),
      .b_d    (b_next[i]),
      .b      (b_lane[i])
    );
  end

  assign bus.b       = b_lane;
  assign bus.tok_cnt = cnt_q;

endmodule

// File: tb/tb_token_divider.sv
module tb_token_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_div = '0;
  logic       cfg_mode = 1'b0;
  logic       cnt_clr = 1'b0;

  always #5 clk = ~clk;

  token_divider_if #(.N_CH(4), .DIV_W(4), .CNT_W(16)) bus16 ();
  token_divider_if #(.N_CH(4), .DIV_W(4), .CNT_W(4))  bus4 ();

  assign bus16.a = a;  assign bus16.cfg_we = cfg_we;  assign bus16.cfg_div = cfg_div;
  assign bus16.cfg_mode = cfg_mode;  assign bus16.cnt_clr = cnt_clr;
  assign bus4.a = a;   assign bus4.cfg_we = cfg_we;   assign bus4.cfg_div = cfg_div;
  assign bus4.cfg_mode = cfg_mode;   assign bus4.cnt_clr = cnt_clr;

  token_divider #(.N_CH(4), .DIV_W(4), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  token_divider #(.N_CH(4), .DIV_W(4), .CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  int tests = 0;
  int failed = 0;
  bit chk_en = 1'b0;

  // Model: per lane, tokens seen since the last reset/config load.
  // The n-th token (0-based) is a hit when n mod K == K-1.
  int unsigned m_tok[4];
  int unsigned m_k = 2;
  bit          m_drop = 1'b0;
  logic [3:0]  exp_b = '0;
  int unsigned exp_c16 = 0;
  int unsigned exp_c4 = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task model_update();
    int unsigned pc;
    bit hit;
    bit nb;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_tok[i] = 0;
      m_k = 2; m_drop = 1'b0; exp_b = '0; exp_c16 = 0; exp_c4 = 0;
    end else begin
      pc = 0;
      for (int i = 0; i < 4; i++) begin
        nb = 1'b0;
        if (a[i]) begin
          hit = ((m_tok[i] % m_k) == (m_k - 1));
          nb = m_drop ? !hit : hit;
          m_tok[i]++;
        end
        exp_b[i] = nb;
        pc += nb;
      end
      if (cfg_we) begin
        for (int i = 0; i < 4; i++) m_tok[i] = 0;
        m_k = (cfg_div == 0) ? 1 : cfg_div;
        m_drop = cfg_mode;
      end
      if (cnt_clr) begin
        exp_c16 = 0; exp_c4 = 0;
      end else begin
        exp_c16 = (exp_c16 + pc > 65535) ? 65535 : exp_c16 + pc;
        exp_c4  = (exp_c4 + pc > 15) ? 15 : exp_c4 + pc;
      end
    end
  endtask

  task automatic step(input logic [3:0] ai, input logic we, input logic [3:0] div,
                      input logic md, input logic clr, input logic r);
    @(negedge clk);
    a = ai; cfg_we = we; cfg_div = div; cfg_mode = md; cnt_clr = clr; rst = r;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("b16", bus16.b, exp_b);
      check("b4", bus4.b, exp_b);
      check("cnt16", bus16.tok_cnt, exp_c16);
      check("cnt4", bus4.tok_cnt, exp_c4);
    end
  end

  initial begin
    logic [15:0] s1;
    logic [15:0] got16;
    logic [8:0]  got9;
    logic [4:0]  got5;
    int          exp5[5];

    // Reset state
    step(4'b0, 0, 4'd0, 0, 0, 1);
    chk_en = 1'b1;
    check("rst_b", bus16.b, 0);
    check("rst_cnt", bus16.tok_cnt, 0);

    // Default K=2 KEEP on lane 0
    step(4'b0, 0, 4'd0, 0, 0, 0);
    s1 = 16'b1100111010001111;
    got16 = '0;
    for (int j = 0; j < 16; j++) begin
      step({3'b0, s1[15-j]}, 0, 4'd0, 0, 0, 0);
      got16[15-j] = bus16.b[0];
    end
    check("halver_seq", got16, 16'b0100010010000101);
    check("halver_cnt", bus16.tok_cnt, 5);

    // K=3 KEEP, then K=3 DROP, lane 1
    step(4'b0, 1, 4'd3, 0, 0, 0);
    for (int j = 0; j < 9; j++) begin
      step(4'b0010, 0, 4'd0, 0, 0, 0);
      got9[8-j] = bus16.b[1];
    end
    check("k3_keep", got9, 9'b001001001);
    step(4'b0, 1, 4'd3, 1, 0, 0);
    for (int j = 0; j < 9; j++) begin
      step(4'b0010, 0, 4'd0, 0, 0, 0);
      got9[8-j] = bus16.b[1];
    end
    check("k3_drop", got9, 9'b110110110);

    // Mid-stream load of K=4 while ph=1 (K=2 KEEP)
    step(4'b0, 1, 4'd2, 0, 0, 0);
    step(4'b0100, 0, 4'd0, 0, 0, 0);
    step(4'b0100, 1, 4'd4, 0, 0, 0);
    got5[4] = bus16.b[2];
    for (int j = 0; j < 4; j++) begin
      step(4'b0100, 0, 4'd0, 0, 0, 0);
      got5[3-j] = bus16.b[2];
    end
    check("midload", got5, 5'b10001);

    // Saturation of the 4-bit counter, then clear while tokens flow
    step(4'b0, 0, 4'd0, 0, 0, 1);
    step(4'b0, 1, 4'd1, 0, 0, 0);
    exp5 = '{4, 8, 12, 15, 15};
    for (int j = 0; j < 5; j++) begin
      step(4'b1111, 0, 4'd0, 0, 0, 0);
      check("sat4", bus4.tok_cnt, exp5[j]);
    end
    step(4'b1111, 0, 4'd0, 0, 1, 0);
    check("clr4", bus4.tok_cnt, 0);
    check("clr16", bus16.tok_cnt, 0);

    // cfg_div = 0 acts as K = 1
    step(4'b0, 1, 4'd0, 0, 0, 0);
    step(4'b1010, 0, 4'd0, 0, 0, 0);
    check("div0_keep_a", bus16.b, 4'b1010);
    step(4'b0101, 0, 4'd0, 0, 0, 0);
    check("div0_keep_b", bus16.b, 4'b0101);
    step(4'b0, 1, 4'd0, 1, 0, 0);
    step(4'b1111, 0, 4'd0, 0, 0, 0);
    check("div0_drop", bus16.b, 0);

    // Reset mid-stream with ph=1
    step(4'b0, 1, 4'd2, 0, 0, 0);
    step(4'b0001, 0, 4'd0, 0, 0, 0);
    step(4'b0001, 0, 4'd0, 0, 0, 1);
    check("rst_mid_b", bus16.b, 0);
    step(4'b0001, 0, 4'd0, 0, 0, 0);
    check("post_rst_first", bus16.b[0], 0);
    step(4'b0001, 0, 4'd0, 0, 0, 0);
    check("post_rst_second", bus16.b[0], 1);

    // Randomized traffic with occasional config loads, clears and resets
    for (int j = 0; j < 600; j++) begin
      step(4'($urandom), ($urandom_range(0, 15) == 0), 4'($urandom),
           1'($urandom), ($urandom_range(0, 31) == 0), ($urandom_range(0, 99) == 0));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/token_divider.md
# token_divider

Multi-channel serial token rate divider, the parametrised successor of the team's single-channel token halver. Each of `N_CH` independent lanes watches a serial stream of '1' tokens. In keep mode a lane forwards every K-th token; in drop mode it suppresses every K-th token. K and the mode are programmable at run time and shared by all lanes. A saturating counter totals the tokens emitted on all lanes. The block sits between serial token producers and rate-limited consumers.

## Interface
Parameters:
- `N_CH`, 4: number of independent lanes (≥1).
- `DIV_W`, 4: width of divisor K; legal K = 1..2^DIV_W−1.
- `CNT_W`, 16: width of emitted-token counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `a`  in  N_CH  input tokens, bit i = lane i.
- `cfg_we`  in  1  load `cfg_div`/`cfg_mode` this cycle.
- `cfg_div`  in  DIV_W  new divisor K; 0 is treated as 1.
- `cfg_mode`  in  1  0 = KEEP (emit every K-th token), 1 = DROP (suppress every K-th token).
- `cnt_clr`  in  1  clear emitted-token counter.
- `b`  out  N_CH  output tokens, registered.
- `tok_cnt`  out  CNT_W  saturating total of '1's driven on `b`.

## Operation
- Per lane i there is a phase counter `ph[i]` in 0..K−1.
- A token on a lane is a **hit** when `a[i]` = 1 and `ph[i]` = K−1.
- On a hit, `ph[i]` becomes 0. When `a[i]` = 1 without a hit, `ph[i]` increments. When `a[i]` = 0, `ph[i]` holds.
- Next value of `b[i]`:
  - KEEP mode: `a[i]` & hit.
  - DROP mode: `a[i]` & ~hit.
  - When `a[i]` = 0, `b[i]` is 0 in both modes.
- K = 1: KEEP is a pass-through of `a`; DROP blocks all tokens.
- Defaults after reset are K = 2, KEEP. With these, each lane's first token is dropped and its second is passed, which is exactly the halving behaviour.
- Config load (`cfg_we` = 1):
  - Tokens arriving in that cycle are evaluated with the old K, mode and phase.
  - The new K and mode then take effect from the next cycle.
  - All `ph[i]` are forced to 0; the phase advance from the load cycle is discarded.
- `cfg_div` = 0 is stored as 1.
- Counter:
  - Each cycle, `tok_cnt` ← min(`tok_cnt` + popcount(next `b`), 2^CNT_W−1).
  - `cnt_clr` has priority: `tok_cnt` ← 0, and that cycle's emitted tokens are not counted.
  - The counter saturates; it never wraps.

## Timing
- Reset values: `b` = 0, `tok_cnt` = 0, all `ph` = 0, K = 2, mode = KEEP.
- `rst` overrides `cfg_we` and `cnt_clr`.
- Latency: `a` sampled at edge t appears on `b` after edge t (one cycle), with no combinational path from `a` to `b`.
- `tok_cnt` updates on the same edge as the `b` it counts.
- Reset mid-stream discards all phase state. The first token after reset is treated as phase 0.
- Lanes are fully independent; simultaneous tokens on all lanes are legal every cycle.
- Simultaneous `cfg_we` and `cnt_clr` are both honoured.

## Structure
- Package `token_divider_pkg`:
  - `typedef enum logic {MODE_KEEP, MODE_DROP} tok_mode_t`.
  - Constants `DEF_DIV` = 2 and `DEF_MODE` = MODE_KEEP.
- Sub-module `token_divider_lane`, instantiated `N_CH` times via generate:
  - Inputs: K, mode, `cfg_we`, `a[i]`.
  - Owns `ph[i]` and the `b[i]` flop.
- Top level holds:
  - the config registers;
  - a combinational popcount over the lanes' next-`b` signals;
  - the saturating counter.

## Test plan
- Default config, lane 0, `a` = 110_011_101_000_1111 → `b` = 010_001_001_000_0101 one cycle later; `tok_cnt` = 5.
- `cfg_we` with K = 3, KEEP; nine consecutive '1's on lane 1 → `b[1]` = 001_001_001; on DROP, same stimulus → 110_110_110.
- Lanes with different interleaved streams, all lanes toggling every cycle → each lane matches its own model; `tok_cnt` equals the summed popcount.
- Mid-stream `cfg_we` with K = 4 while `ph` = 1 → load-cycle token judged under old K; next hit occurs on the 4th subsequent token.
- `CNT_W` = 4, K = 1 KEEP, all 4 lanes high → `tok_cnt` goes 4, 8, 12, 15, 15; `cnt_clr` asserted while tokens flow → `tok_cnt` = 0.
- `cfg_div` = 0 → behaves as K = 1. Assert `rst` mid-stream with `ph` = 1 → `b` = 0 next cycle; with default K = 2, the first post-reset token is dropped.
